vga_timing: RTL and testbench

Pixel-timing generator and output stage for the VGA path. Produces the raster coordinates `x`/`y` consumed by the pattern generators (bars and similar). Samples the generator's combinational 30-bit `rgb` answer and drives registered `vga_rgb`, `hsync_n`, `vsync_n` and `blank_n` to the DAC pins, all aligned to the same pixel. Default timing is 640x480@60 on a 25 MHz pixel rate, selected by a clock enable.

---
 rtl/vga_timing.sv | 111 +++++++++++
 tb/tb_vga_timing.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator with a one-pixel registered output stage.
// Produces raw x/y counters and drives colour, syncs and blank to the DAC.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pix_en,
   input  logic [29:0] rgb_in,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        active,
   output logic        frame_start,
   output logic [29:0] vga_rgb,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        blank_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [29:0] vga_rgb_q, vga_rgb_d;
   logic        hsync_n_q, hsync_n_d;
   logic        vsync_n_q, vsync_n_d;
   logic        blank_n_q, blank_n_d;
   logic        frame_start_q, frame_start_d;

   logic        active_c;
   logic        h_sync_region;
   logic        v_sync_region;
   logic        line_end;
   logic        frame_end;

   always_comb begin
      active_c      = (x_q < H_ACT) && (y_q < V_ACT);
      h_sync_region = (x_q >= HS_START) && (x_q < HS_END);
      v_sync_region = (y_q >= VS_START) && (y_q < VS_END);
      line_end      = (x_q == H_LAST);
      frame_end     = line_end && (y_q == V_LAST);

      x_d       = x_q;
      y_d       = y_q;
      vga_rgb_d = vga_rgb_q;
      hsync_n_d = hsync_n_q;
      vsync_n_d = vsync_n_q;
      blank_n_d = blank_n_q;
      // The pulse must drop on the very next clk, enabled or not.
      frame_start_d = pix_en && frame_end;

      if (pix_en) begin
         x_d = line_end ? 10'd0 : x_q + 10'd1;
         if (line_end) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
         end
         // Output stage works from the pre-update position so all DAC pins align.
         vga_rgb_d = active_c ? rgb_in : 30'd0;
         blank_n_d = active_c;
         hsync_n_d = !h_sync_region;
         vsync_n_d = !v_sync_region;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         vga_rgb_q     <= 30'd0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         vga_rgb_q     <= vga_rgb_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign active      = active_c;
   assign frame_start = frame_start_q;
   assign vga_rgb     = vga_rgb_q;
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign blank_n     = blank_n_q;

endmodule

// File: tb/tb_vga_timing.sv
// Randomized bench for vga_timing on a shrunk raster, checked against a
// reference that derives everything from the count of enabled pixels since reset.
module tb_vga_timing;

   localparam int HA = 16, HF = 4, HS = 6, HB = 5;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_en;
   logic [29:0] rgb_in;
   logic [29:0] rgb_rand;
   logic        bars_mode;
   logic [9:0]  x, y;
   logic        active, frame_start, hsync_n, vsync_n, blank_n;
   logic [29:0] vga_rgb;

   int checks = 0;
   int errors = 0;

   // reference state: enabled pixels since reset, and what the last edge sampled
   int          n;
   logic        last_en;
   logic [29:0] last_rgb;
   int          en_mode;

   always #5 clk = ~clk;

   function automatic logic [29:0] bars_color(input int px, input int py);
      if (px < 4 && py < 4) return {10'h3FF, 20'd0};
      if (px >= 8 && px < 12) return {10'd0, 10'h155, 10'd0};
      return {20'd0, 10'h2AA};
   endfunction

   assign rgb_in = bars_mode ? bars_color(int'(x), int'(y)) : rgb_rand;

   vga_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .rgb_in(rgb_in),
      .x(x), .y(y), .active(active), .frame_start(frame_start),
      .vga_rgb(vga_rgb), .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (n=%0d t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   task automatic check_all();
      int ex, ey, px, py;
      logic e_act, p_act;
      ex = n % HT;
      ey = (n / HT) % VT;
      e_act = (ex < HA) && (ey < VA);
      check("x", 32'(x), 32'(ex));
      check("y", 32'(y), 32'(ey));
      check("active", 32'(active), 32'(e_act));
      check("frame_start", 32'(frame_start), 32'(last_en && n > 0 && (n % FRAME) == 0));
      if (n == 0) begin
         check("vga_rgb", 32'(vga_rgb), 32'd0);
         check("hsync_n", 32'(hsync_n), 32'd1);
         check("vsync_n", 32'(vsync_n), 32'd1);
         check("blank_n", 32'(blank_n), 32'd0);
      end else begin
         px = (n - 1) % HT;
         py = ((n - 1) / HT) % VT;
         p_act = (px < HA) && (py < VA);
         check("vga_rgb", 32'(vga_rgb), p_act ? 32'(last_rgb) : 32'd0);
         check("hsync_n", 32'(hsync_n), 32'(!(px >= HA + HF && px < HA + HF + HS)));
         check("vsync_n", 32'(vsync_n), 32'(!(py >= VA + VF && py < VA + VF + VS)));
         check("blank_n", 32'(blank_n), 32'(p_act));
      end
   endtask

   task automatic drive();
      rgb_rand = 30'($urandom());
      case (en_mode)
         0: pix_en = 1'b1;
         1: pix_en = ~pix_en;
         default: pix_en = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      last_en = reset_n && pix_en;
      if (last_en) begin
         last_rgb = bars_mode ? bars_color(n % HT, (n / HT) % VT) : rgb_rand;
         n++;
      end
      @(negedge clk);
      check_all();
      drive();
   endtask

   initial begin
      bit hit;
      reset_n   = 1'b0;
      pix_en    = 1'b0;
      rgb_rand  = 30'd0;
      bars_mode = 1'b0;
      en_mode   = 0;
      n         = 0;
      last_en   = 1'b0;
      last_rgb  = 30'd0;

      repeat (2) @(negedge clk);
      check_all();
      reset_n = 1'b1;
      drive();

      // continuous enable, full-scale and random colours
      rgb_rand = 30'h3FFFFFFF;
      repeat (FRAME + 40) step();

      // enable toggling every clk
      en_mode = 1;
      repeat (HT * 6) step();

      // irregular enable with a bars pattern fed back from x/y
      en_mode   = 2;
      bars_mode = 1'b1;
      repeat (FRAME + 60) step();
      bars_mode = 1'b0;

      // run to a mid-frame position, then reset asynchronously between edges
      en_mode = 0;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         if ((n % HT) == 10 && ((n / HT) % VT) == 5) hit = 1'b1;
         else step();
      end
      check("reach_midframe", 32'(hit), 32'd1);
      #1 reset_n = 1'b0;
      n = 0;
      last_en = 1'b0;
      #1 check_all();
      step();
      reset_n = 1'b1;

      // first frame_start after release must take a full frame of enabled pixels
      repeat (FRAME + 20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
